// File: rtl/cnn_layer_accel_slave_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cnn_layer_accel_slave_regfile
// Function : SAP slave burst decoder onto a bank of C_NUM_REGS registers.
//            Optional shadow output bank: CNN_LAYER_ACCEL_REG_SHADOW_EN.
// Revision : 1.0
// ============================================================================
module cnn_layer_accel_slave_regfile #(
  parameter int unsigned           C_NUM_REGS   = 8,
  parameter int unsigned           C_DATA_WIDTH = 128,
  parameter int unsigned           C_ADDR_LSB   = 4,
  parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [12:0]                        slave_burst_length,
  input  logic                               slave_burst_rnw,
  input  logic [63:0]                        slave_address,
  input  logic                               slave_address_valid,
  output logic                               slave_address_ack,
  input  logic [3:0]                         slave_wrreq,
  output logic                               slave_wrack,
  input  logic [C_DATA_WIDTH/8-1:0]          slave_be,
  input  logic [C_DATA_WIDTH-1:0]            slave_datain,
  input  logic [3:0]                         slave_rdreq,
  output logic                               slave_rdack,
  output logic [C_DATA_WIDTH-1:0]            slave_dataout,
  input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] status_in,
  input  logic                               reg_commit,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
  output logic [C_NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int unsigned C_IDX_W = $clog2(C_NUM_REGS);
  localparam int unsigned C_BYTES = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [C_IDX_W-1:0]      idx_q, idx_d;
  logic [12:0]             cnt_q, cnt_d;
  logic                    oor_q, oor_d;
  logic                    addr_ack_q, addr_ack_d;
  logic                    rdack_q, rdack_d;
  logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [C_NUM_REGS-1:0]   pulse_q, pulse_d;
  logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];

  logic [C_IDX_W-1:0] addr_idx;
  logic [63:0]        addr_hi;
  logic [63:0]        addr_lo;
  logic               addr_oor;
  logic [C_IDX_W-1:0] idx_next;
  logic               idx_ro;
  logic               wr_beat;
  logic               rd_beat;
  logic               wr_en;
  logic               last_beat;
  logic               unused_inputs;

  // Any address bit outside the index field makes the whole burst a sink.
  assign addr_idx = slave_address[C_ADDR_LSB +: C_IDX_W];
  assign addr_hi  = slave_address >> (C_ADDR_LSB + C_IDX_W);
  assign addr_lo  = slave_address & ((64'd1 << C_ADDR_LSB) - 64'd1);
  assign addr_oor = ({1'b0, addr_idx} >= (C_IDX_W+1)'(C_NUM_REGS)) ||
                    (addr_hi != 64'd0) || (addr_lo != 64'd0);

  assign idx_next  = (idx_q == C_IDX_W'(C_NUM_REGS - 1)) ? '0 : idx_q + 1'b1;
  assign idx_ro    = C_RO_MASK[idx_q];
  assign last_beat = (cnt_q == 13'd1);
  // Beats are masked during reset so an aborted burst produces no acks.
  assign wr_beat   = (state_q == S_WR) && slave_wrreq[0] && !rst;
  assign rd_beat   = (state_q == S_RD) && slave_rdreq[0] && !rst;
  assign wr_en     = wr_beat && !oor_q && !idx_ro;

  assign slave_wrack       = wr_beat;
  assign slave_address_ack = addr_ack_q;
  assign slave_rdack       = rdack_q;
  assign slave_dataout     = rdata_q;
  assign reg_wr_pulse      = pulse_q;
  assign unused_inputs     = ^{slave_wrreq[3:1], slave_rdreq[3:1], reg_commit};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    oor_d      = oor_q;
    addr_ack_d = 1'b0;
    rdack_d    = 1'b0;
    rdata_d    = '0;
    pulse_d    = '0;
    regs_d     = regs_q;
    case (state_q)
      S_IDLE: begin
        if (slave_address_valid) begin
          idx_d      = addr_idx;
          cnt_d      = (slave_burst_length == 13'd0) ? 13'd1 : slave_burst_length;
          oor_d      = addr_oor;
          addr_ack_d = 1'b1;
          state_d    = slave_burst_rnw ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (wr_beat) begin
          if (wr_en) begin
            for (int b = 0; b < C_BYTES; b++) begin
              if (slave_be[b]) regs_d[idx_q][b*8 +: 8] = slave_datain[b*8 +: 8];
            end
            pulse_d[idx_q] = 1'b1;
          end
          idx_d = idx_next;
          cnt_d = cnt_q - 13'd1;
          if (last_beat) state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (rd_beat) begin
          rdack_d = 1'b1;
          if (!oor_q) begin
            rdata_d = idx_ro ? status_in[int'(idx_q)*C_DATA_WIDTH +: C_DATA_WIDTH]
                             : regs_q[idx_q];
          end
          idx_d = idx_next;
          cnt_d = cnt_q - 13'd1;
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      oor_q      <= 1'b0;
      addr_ack_q <= 1'b0;
      rdack_q    <= 1'b0;
      rdata_q    <= '0;
      pulse_q    <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      oor_q      <= oor_d;
      addr_ack_q <= addr_ack_d;
      rdack_q    <= rdack_d;
      rdata_q    <= rdata_d;
      pulse_q    <= pulse_d;
      for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef CNN_LAYER_ACCEL_REG_SHADOW_EN
  logic [C_DATA_WIDTH-1:0] shadow_q [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] shadow_d [C_NUM_REGS];

  always_comb begin
    shadow_d = shadow_q;
    if (reg_commit) shadow_d = regs_q;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (rst) shadow_q[i] <= '0;
      else     shadow_q[i] <= shadow_d[i];
    end
  end

  generate
    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
      assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = shadow_q[i];
    end
  endgenerate
`else
  generate
    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
      assign reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[i];
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_accel_slave_regfile.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cnn_layer_accel_slave_regfile
// Function : Directed vector bench for cnn_layer_accel_slave_regfile.
// Revision : 1.0
// ============================================================================
module tb_cnn_layer_accel_slave_regfile;

  localparam int NR = 8;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [12:0]     slave_burst_length;
  logic            slave_burst_rnw;
  logic [63:0]     slave_address;
  logic            slave_address_valid;
  logic            slave_address_ack;
  logic [3:0]      slave_wrreq;
  logic            slave_wrack;
  logic [DW/8-1:0] slave_be;
  logic [DW-1:0]   slave_datain;
  logic [3:0]      slave_rdreq;
  logic            slave_rdack;
  logic [DW-1:0]   slave_dataout;
  logic [NR*DW-1:0] status_in;
  logic            reg_commit;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]   reg_wr_pulse;

  int checks   = 0;
  int failures = 0;

  cnn_layer_accel_slave_regfile #(
    .C_NUM_REGS  (NR),
    .C_DATA_WIDTH(DW),
    .C_ADDR_LSB  (4),
    .C_RO_MASK   (8'h10)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .slave_burst_length (slave_burst_length),
    .slave_burst_rnw    (slave_burst_rnw),
    .slave_address      (slave_address),
    .slave_address_valid(slave_address_valid),
    .slave_address_ack  (slave_address_ack),
    .slave_wrreq        (slave_wrreq),
    .slave_wrack        (slave_wrack),
    .slave_be           (slave_be),
    .slave_datain       (slave_datain),
    .slave_rdreq        (slave_rdreq),
    .slave_rdack        (slave_rdack),
    .slave_dataout      (slave_dataout),
    .status_in          (status_in),
    .reg_commit         (reg_commit),
    .reg_out            (reg_out),
    .reg_wr_pulse       (reg_wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic         rnw;
    logic [63:0]  addr;
    logic [12:0]  len;
    logic [15:0]  be;
    logic [127:0] data;
    logic [7:0]   exp_pulse;
    int           idx;
    logic [127:0] exp_val;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] slice(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  // Called at posedge+1; returns at posedge+1 of the ack cycle.
  task automatic addr_phase(input string nm, input logic rnw, input logic [63:0] a,
                            input logic [12:0] len);
    int n;
    slave_address       = a;
    slave_burst_rnw     = rnw;
    slave_burst_length  = len;
    slave_address_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!slave_address_ack && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_addr_ack"}, slave_address_ack, 1'b1);
    slave_address_valid = 1'b0;
  endtask

  task automatic wr_beat(input string nm, input logic [15:0] be, input logic [127:0] d,
                         input logic exp_ack);
    slave_be     = be;
    slave_datain = d;
    slave_wrreq  = 4'b0001;
    #1;
    chk({nm, "_wrack"}, slave_wrack, exp_ack);
    @(posedge clk); #1;
    slave_wrreq  = 4'b0000;
  endtask

  task automatic out_settle();
`ifdef CNN_LAYER_ACCEL_REG_SHADOW_EN
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    rst = 1'b1;
    slave_burst_length = '0; slave_burst_rnw = 1'b0; slave_address = '0;
    slave_address_valid = 1'b0; slave_wrreq = '0; slave_be = '0; slave_datain = '0;
    slave_rdreq = '0;
`ifdef CNN_LAYER_ACCEL_REG_SHADOW_EN
    reg_commit = 1'b1;
`else
    reg_commit = 1'b0;
`endif
    for (int i = 0; i < NR; i++)
      status_in[i*DW +: DW] = (i == 4) ? 128'h1234 : 128'hDEAD0000 + 128'(i);

    vecs[0]  = '{1'b0, 64'h20,   13'd1, 16'hFFFF, {16{8'hA5}},         8'h04, 2, {16{8'hA5}}};
    vecs[1]  = '{1'b1, 64'h20,   13'd1, 16'h0000, 128'h0,              8'h00, 2, {16{8'hA5}}};
    vecs[2]  = '{1'b0, 64'h10,   13'd1, 16'h000F, {16{8'hFF}},         8'h02, 1, {96'h0, 32'hFFFFFFFF}};
    vecs[3]  = '{1'b1, 64'h10,   13'd1, 16'h0000, 128'h0,              8'h00, 1, {96'h0, 32'hFFFFFFFF}};
    vecs[4]  = '{1'b0, 64'h40,   13'd1, 16'hFFFF, 128'hFFFF,           8'h00, 4, 128'h0};
    vecs[5]  = '{1'b1, 64'h40,   13'd0, 16'h0000, 128'h0,              8'h00, 4, 128'h1234};
    vecs[6]  = '{1'b0, 64'h1000, 13'd1, 16'hFFFF, {16{8'hFF}},         8'h00, 0, 128'h0};
    vecs[7]  = '{1'b1, 64'h1000, 13'd1, 16'h0000, 128'h0,              8'h00, 0, 128'h0};
    vecs[8]  = '{1'b0, 64'h28,   13'd1, 16'hFFFF, {16{8'hFF}},         8'h00, 2, {16{8'hA5}}};
    vecs[9]  = '{1'b0, 64'h20,   13'd1, 16'h8000, {8'h11, 120'h0},     8'h04, 2, {8'h11, {15{8'hA5}}}};
    vecs[10] = '{1'b0, 64'h30,   13'd0, 16'h0000, {16{8'hFF}},         8'h08, 3, 128'h0};
    vecs[11] = '{1'b1, 64'h20,   13'd1, 16'h0000, 128'h0,              8'h00, 2, {8'h11, {15{8'hA5}}}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_ack", slave_address_ack, 1'b0);
    chk("rst_wrack",    slave_wrack,       1'b0);
    chk("rst_rdack",    slave_rdack,       1'b0);
    chk("rst_dataout",  slave_dataout,     128'h0);
    chk("rst_pulse",    reg_wr_pulse,      8'h00);
    chk("rst_reg_out_zero", (reg_out == '0), 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      addr_phase($sformatf("v%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].len);
      if (!vecs[i].rnw) begin
        wr_beat($sformatf("v%0d", i), vecs[i].be, vecs[i].data, 1'b1);
        chk($sformatf("v%0d_pulse", i), reg_wr_pulse, vecs[i].exp_pulse);
        out_settle();
        chk($sformatf("v%0d_reg_out", i), slice(vecs[i].idx), vecs[i].exp_val);
      end else begin
        slave_rdreq = 4'b0001;
        @(posedge clk); #1;
        slave_rdreq = 4'b0000;
        chk($sformatf("v%0d_rdack", i), slave_rdack, 1'b1);
        chk($sformatf("v%0d_rdata", i), slave_dataout, vecs[i].exp_val);
        chk($sformatf("v%0d_pulse", i), reg_wr_pulse, 8'h00);
        @(posedge clk); #1;
        chk($sformatf("v%0d_rd_idle", i), {slave_rdack, slave_dataout}, 129'h0);
      end
    end

    // Four-beat write wrapping from register 6 back to 0.
    addr_phase("wrap_wr", 1'b0, 64'h60, 13'd4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_p;
      exp_p = (i == 0) ? 8'h40 : (i == 1) ? 8'h80 : (i == 2) ? 8'h01 : 8'h02;
      wr_beat($sformatf("wrap_b%0d", i), 16'hFFFF, 128'(i + 1), 1'b1);
      chk($sformatf("wrap_b%0d_pulse", i), reg_wr_pulse, exp_p);
    end
    wr_beat("wrap_extra", 16'hFFFF, 128'd99, 1'b0);
    out_settle();
    chk("wrap_r6", slice(6), 128'd1);
    chk("wrap_r7", slice(7), 128'd2);
    chk("wrap_r0", slice(0), 128'd3);
    chk("wrap_r1", slice(1), 128'd4);

    addr_phase("wrap_rd", 1'b1, 64'h60, 13'd4);
    slave_wrreq = 4'b0001;
    #1;
    chk("rd_wrreq_ignored", slave_wrack, 1'b0);
    slave_rdreq = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) slave_rdreq = 4'b0000;
      chk($sformatf("wrap_rd%0d_ack", i), slave_rdack, 1'b1);
      chk($sformatf("wrap_rd%0d_data", i), slave_dataout, 128'(i + 1));
    end
    slave_wrreq = 4'b0000;
    @(posedge clk); #1;
    chk("wrap_rd_done", slave_rdack, 1'b0);

    // Reset in the middle of a four-beat write.
    addr_phase("rstb", 1'b0, 64'h00, 13'd4);
    wr_beat("rstb_b0", 16'hFFFF, {16{8'hAA}}, 1'b1);
    wr_beat("rstb_b1", 16'hFFFF, {16{8'hAA}}, 1'b1);
    slave_wrreq = 4'b0001;
    rst = 1'b1;
    #1;
    chk("rstb_wrack_in_rst", slave_wrack, 1'b0);
    @(posedge clk); #1;
    chk("rstb_wrack_after", slave_wrack, 1'b0);
    chk("rstb_regs_zero", (reg_out == '0), 1'b1);
    chk("rstb_pulse", reg_wr_pulse, 8'h00);
    rst = 1'b0;
    slave_wrreq = 4'b0000;
    slave_address = 64'h60; slave_burst_rnw = 1'b1; slave_burst_length = 13'd1;
    slave_address_valid = 1'b1;
    @(posedge clk); #1;
    chk("rstb_new_addr_ack", slave_address_ack, 1'b1);
    slave_address_valid = 1'b0;
    slave_rdreq = 4'b0001;
    @(posedge clk); #1;
    slave_rdreq = 4'b0000;
    chk("rstb_rd_ack", slave_rdack, 1'b1);
    chk("rstb_rd_data", slave_dataout, 128'h0);

`ifdef CNN_LAYER_ACCEL_REG_SHADOW_EN
    reg_commit = 1'b0;
    addr_phase("shd", 1'b0, 64'h30, 13'd1);
    wr_beat("shd", 16'hFFFF, 128'h55, 1'b1);
    chk("shd_pulse", reg_wr_pulse, 8'h08);
    @(posedge clk); #1;
    chk("shd_out_held", slice(3), 128'h0);
    addr_phase("shd_rd", 1'b1, 64'h30, 13'd1);
    slave_rdreq = 4'b0001;
    @(posedge clk); #1;
    slave_rdreq = 4'b0000;
    chk("shd_live_rd", slave_dataout, 128'h55);
    reg_commit = 1'b1;
    @(posedge clk); #1;
    reg_commit = 1'b0;
    chk("shd_committed", slice(3), 128'h55);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
